// File: rtl/probe_capture.sv
// Triggered capture buffer: pre/post-trigger sample window written to a ring RAM,
// then streamed out over a valid/ready port.
module probe_capture #(
  parameter int DATA_W = 52,
  parameter int TRIG_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic [TRIG_W-1:0] trig_val_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              busy_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              rd_last_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DUMP
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] xfer_q;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] trig_addr_q;
  logic [TRIG_W-1:0] val_q;
  logic [TRIG_W-1:0] mask_q;
  logic              busy_q;
  logic              done_q;
  logic              trig_q;
  logic              rd_valid_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rd_q;

  logic hit;
  logic wr_en;
  logic xfer;
  logic last;
  logic post_end;

  assign hit = valid_i &&
               (((trig_i ^ val_q) & mask_q) == '0);

  assign wr_en = valid_i &&
                 (state_q == S_PRE ||
                  state_q == S_WAIT ||
                  (state_q == S_POST && cnt_q != '0));

  assign post_end = (cnt_q == '0) ||
                    (valid_i && cnt_q == ADDR_W'(1));

  assign xfer = rd_valid_q && rd_ready_i;
  assign last = (xfer_q == '1);

  // Read address advances on a transfer, so a stall re-reads the same word.
  assign rd_ptr_d = (state_q == S_DUMP && xfer) ?
                    rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= data_i;
    ram_rd_q <= mem[rd_ptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      xfer_q      <= '0;
      pre_q       <= '0;
      trig_addr_q <= '0;
      val_q       <= '0;
      mask_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trig_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      unique case (state_q)
        S_IDLE: begin
          if (arm_i) begin
            pre_q    <= pretrig_i;
            val_q    <= trig_val_i;
            mask_q   <= trig_mask_i;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            xfer_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= (pretrig_i == '0) ? S_WAIT : S_PRE;
          end
        end
        S_PRE: begin
          if (valid_i) begin
            cnt_q <= cnt_q + ADDR_W'(1);
            if (cnt_q + ADDR_W'(1) == pre_q) state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (hit) begin
            trig_addr_q <= wr_ptr_q;
            trig_q      <= 1'b1;
            cnt_q       <= ~pre_q;
            state_q     <= S_POST;
          end
        end
        S_POST: begin
          if (wr_en) cnt_q <= cnt_q - ADDR_W'(1);
          if (post_end) begin
            state_q    <= S_DUMP;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            rd_ptr_q   <= trig_addr_q - pre_q;
            xfer_q     <= '0;
            rd_valid_q <= 1'b0;
          end
        end
        S_DUMP: begin
          if (!rd_valid_q) begin
            rd_valid_q <= 1'b1;
          end else if (rd_ready_i) begin
            xfer_q <= xfer_q + ADDR_W'(1);
            if (last) begin
              state_q    <= S_IDLE;
              done_q     <= 1'b0;
              trig_q     <= 1'b0;
              rd_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign triggered_o = trig_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_valid_q ? ram_rd_q : '0;
  assign rd_last_o   = rd_valid_q && last;

endmodule

// File: tb/tb_probe_capture.sv
// Scoreboard bench for probe_capture: expected readout window is queued
// as samples are driven and checked word-by-word during the dump.
module tb_probe_capture;

  localparam int DW = 52;
  localparam int TW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic [AW-1:0] pretrig;
  logic [TW-1:0] tval;
  logic [TW-1:0] tmask;
  logic [TW-1:0] trig;
  logic [DW-1:0] data;
  logic          valid;
  logic          busy;
  logic          trg;
  logic          done;
  logic [DW-1:0] rdd;
  logic          rdv;
  logic          rdy;
  logic          rdl;

  always #5 clk = ~clk;

  probe_capture #(
    .DATA_W(DW),
    .TRIG_W(TW),
    .ADDR_W(AW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .arm_i      (arm),
    .pretrig_i  (pretrig),
    .trig_val_i (tval),
    .trig_mask_i(tmask),
    .trig_i     (trig),
    .data_i     (data),
    .valid_i    (valid),
    .busy_o     (busy),
    .triggered_o(trg),
    .done_o     (done),
    .rd_data_o  (rdd),
    .rd_valid_o (rdv),
    .rd_ready_i (rdy),
    .rd_last_o  (rdl)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_trg"}, 64'(trg), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_rdv"}, 64'(rdv), 64'(0));
    chk({tag, "_rdl"}, 64'(rdl), 64'(0));
    chk({tag, "_rdd"}, 64'(rdd), 64'(0));
  endtask

  task automatic capture(input int pre, input int v, input int m,
                         input bit gap, input bit arm_mid);
    logic [DW-1:0] hist[$];
    int n, cnt, post, extra, cyc, dn, rv;
    bit hit, hit_prev;
    pretrig = AW'(pre);
    tval = TW'(v);
    tmask = TW'(m);
    arm = 1'b1;
    valid = 1'b0;
    tick();
    arm = 1'b0;
    pretrig = ~AW'(pre);
    tval = ~TW'(v);
    tmask = ~TW'(m);
    chk("arm_busy", 64'(busy), 64'(1));
    n = 0; cnt = 0; post = DEPTH - 1 - pre;
    extra = 0; cyc = 0; dn = -1; rv = -1;
    hit = 1'b0; hit_prev = 1'b0;
    while (extra < 6 && cyc < 2000) begin
      if (hit_prev) chk("trig_set", 64'(trg), 64'(1));
      hit_prev = 1'b0;
      if (done && dn < 0) dn = cyc;
      if (rdv && rv < 0) rv = cyc;
      chk("excl", 64'(busy && done), 64'(0));
      data = DW'(n);
      trig = TW'(n);
      if (!hit || post > 0) begin
        valid = gap ? (n[0] == 1'b0) : 1'b1;
        arm = arm_mid && !hit && valid && cnt == pre + 2;
        if (valid) begin
          if (hit) begin
            exp_q.push_back(data);
            post--;
          end else begin
            hist.push_back(data);
            if (cnt >= pre && ((trig ^ TW'(v)) & TW'(m)) == '0) begin
              hit = 1'b1;
              hit_prev = 1'b1;
              chk("trig_pre", 64'(trg), 64'(0));
              for (int i = cnt - pre; i <= cnt; i++)
                exp_q.push_back(hist[i]);
            end
            cnt++;
          end
        end
      end else begin
        valid = 1'b1;
        arm = 1'b0;
        extra++;
      end
      n++;
      tick();
      cyc++;
    end
    valid = 1'b0;
    arm = 1'b0;
    while (rv < 0 && cyc < 2100) begin
      if (done && dn < 0) dn = cyc;
      if (rdv) rv = cyc;
      if (rv < 0) begin
        tick();
        cyc++;
      end
    end
    chk("dump_lat", 64'(rv >= 0 && dn >= 0 && rv - dn <= 2), 64'(1));
    chk("done_up", 64'(done), 64'(1));
    chk("busy_end", 64'(busy), 64'(0));
    chk("trg_held", 64'(trg), 64'(1));
  endtask

  task automatic drain(input bit bp, input int rst_at);
    int idx, hold, cyc;
    bit tog, stalled, fin;
    logic [DW-1:0] prev, e;
    idx = 0; hold = 0; cyc = 0;
    tog = 1'b0; stalled = 1'b0; fin = 1'b0;
    prev = '0;
    while (!fin && cyc < 400) begin
      if (rst_at >= 0 && idx == rst_at && rdv) begin
        rst = 1'b1;
        rdy = 1'b1;
        tick();
        rst = 1'b0;
        rdy = 1'b0;
        chk_zero("rst_mid");
        for (int k = 0; k < 4; k++) begin
          tick();
          chk("rst_quiet", 64'(rdv), 64'(0));
        end
        exp_q.delete();
        return;
      end
      if (!bp || idx < 7) rdy = 1'b1;
      else if (hold < 5) begin
        rdy = 1'b0;
        if (rdv) hold++;
      end else begin
        rdy = tog;
        tog = ~tog;
      end
      if (rdv) begin
        if (stalled) chk("stable", 64'(rdd), 64'(prev));
        if (rdy) begin
          if (exp_q.size() == 0) begin
            chk("extra_word", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("data", 64'(rdd), 64'(e));
            chk("last", 64'(rdl), 64'(idx == DEPTH - 1));
          end
          idx++;
          if (idx == DEPTH) fin = 1'b1;
        end
        stalled = !rdy;
        prev = rdd;
      end
      tick();
      cyc++;
    end
    rdy = 1'b0;
    chk("xfers", 64'(idx), 64'(DEPTH));
    chk("q_empty", 64'(exp_q.size()), 64'(0));
    chk_zero("idle");
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    pretrig = '0;
    tval = '0;
    tmask = '0;
    trig = '0;
    data = '0;
    valid = 1'b0;
    rdy = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    capture(4, 'h0010, 'hFFFF, 1'b0, 1'b0);
    drain(1'b0, -1);
    capture(4, 'h0040, 'hFFFF, 1'b0, 1'b0);
    drain(1'b1, -1);
    capture(0, 'h1234, 'h0000, 1'b0, 1'b0);
    drain(1'b0, -1);
    capture(15, 'h0020, 'hFFFF, 1'b0, 1'b0);
    drain(1'b0, -1);
    capture(3, 'hAB30, 'h00F0, 1'b1, 1'b1);
    drain(1'b0, -1);
    capture(4, 'h0018, 'hFFFF, 1'b0, 1'b0);
    drain(1'b0, 9);
    capture(2, 'h0025, 'hFFFF, 1'b0, 1'b0);
    drain(1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
